// File: rtl/lwe_row_accumulator.sv
// Reduces two-lane masked A*s products to one 16-bit LWE inner product per row (mod 2^16),
// with beat-index sequencing check. Define ROW_ACC_ERROR_EN to add e_in to each row result.
module lwe_row_accumulator #(
    parameter int ROW_LEN = 8,
    parameter int ROWS    = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        B_valid,
    input  logic [31:0] B_in,
    input  logic [9:0]  idx_in,
    input  logic [9:0]  h_in,
`ifdef ROW_ACC_ERROR_EN
    input  logic [15:0] e_in,
`endif
    output logic        b_valid,
    output logic [15:0] b_out,
    output logic [9:0]  b_row,
    output logic [9:0]  h_out,
    output logic        matrix_done,
    output logic        seq_err
);

    localparam int BEATS  = ROW_LEN / 2;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [9:0]        LAST_ROW  = 10'(ROWS - 1);
    localparam logic [9:0]        LAST_IDX  = 10'(ROWS * BEATS - 1);
    localparam logic              ONE_BEAT  = (BEATS == 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        acc_q, acc_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [9:0]         row_cnt_q, row_cnt_d;
    logic [9:0]         exp_idx_q, exp_idx_d;
    logic               seq_err_q, seq_err_d;
    logic               b_valid_q, b_valid_d;
    logic               matrix_done_q, matrix_done_d;
    logic [15:0]        b_out_q, b_out_d;
    logic [9:0]         b_row_q, b_row_d;
    logic [9:0]         h_out_q, h_out_d;

    logic [15:0]        lane [2];
    logic [15:0]        lane_sum;
    logic [15:0]        acc_sum;
    logic [15:0]        row_result;
    logic               final_beat;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane[gi] = B_in[gi*16 +: 16];
        end
    endgenerate

    assign lane_sum = lane[0] + lane[1];

    // First beat of a row restarts from its own lanes, never from the stale accumulator.
    assign acc_sum    = (state_q == IDLE) ? lane_sum : (acc_q + lane_sum);
    assign final_beat = (state_q == IDLE) ? ONE_BEAT : (beat_cnt_q == LAST_BEAT);

`ifdef ROW_ACC_ERROR_EN
    assign row_result = acc_sum + e_in;
`else
    assign row_result = acc_sum;
`endif

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        beat_cnt_d    = beat_cnt_q;
        row_cnt_d     = row_cnt_q;
        exp_idx_d     = exp_idx_q;
        seq_err_d     = seq_err_q;
        b_valid_d     = 1'b0;
        matrix_done_d = 1'b0;
        b_out_d       = b_out_q;
        b_row_d       = b_row_q;
        h_out_d       = h_out_q;

        if (B_valid) begin
            // A mismatched index is flagged but the beat is still consumed normally.
            if (idx_in != exp_idx_q) begin
                seq_err_d = 1'b1;
            end
            exp_idx_d = (exp_idx_q == LAST_IDX) ? 10'd0 : exp_idx_q + 10'd1;
            acc_d     = acc_sum;

            if (final_beat) begin
                state_d       = IDLE;
                beat_cnt_d    = '0;
                b_valid_d     = 1'b1;
                b_out_d       = row_result;
                b_row_d       = row_cnt_q;
                h_out_d       = h_in;
                matrix_done_d = (row_cnt_q == LAST_ROW);
                row_cnt_d     = (row_cnt_q == LAST_ROW) ? 10'd0 : row_cnt_q + 10'd1;
            end else begin
                state_d    = ACCUM;
                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            beat_cnt_q    <= '0;
            row_cnt_q     <= '0;
            exp_idx_q     <= '0;
            seq_err_q     <= 1'b0;
            b_valid_q     <= 1'b0;
            matrix_done_q <= 1'b0;
            b_out_q       <= '0;
            b_row_q       <= '0;
            h_out_q       <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            beat_cnt_q    <= beat_cnt_d;
            row_cnt_q     <= row_cnt_d;
            exp_idx_q     <= exp_idx_d;
            seq_err_q     <= seq_err_d;
            b_valid_q     <= b_valid_d;
            matrix_done_q <= matrix_done_d;
            b_out_q       <= b_out_d;
            b_row_q       <= b_row_d;
            h_out_q       <= h_out_d;
        end
    end

    assign b_valid     = b_valid_q;
    assign b_out       = b_out_q;
    assign b_row       = b_row_q;
    assign h_out       = h_out_q;
    assign matrix_done = matrix_done_q;
    assign seq_err     = seq_err_q;

endmodule

// File: doc/lwe_row_accumulator.md
# lwe_row_accumulator

Consumes the two-lane masked products from the public/private multiply stage (each beat carries two 16-bit lanes of A·s, already zeroed where the secret bit is 0). Reduces them to one 16-bit LWE inner-product value per matrix row, modulo 2^16. It sits directly downstream of the multiply stage and feeds the B-vector store / transmit path. It also tracks the expected beat index, flags sequencing errors, and passes the 10-bit tag `h` alongside each result.

## Interface
- `ROW_LEN`, 8: elements per row; must be even and ≥ 2; beats per row `BEATS = ROW_LEN/2`.
- `ROWS`, 4: rows per matrix; `ROWS*BEATS ≤ 1024`.
- `clk_in` input 1: single clock; all logic on rising edge.
- `rst_in` input 1: synchronous, active-high reset.
- `B_valid` input 1: beat valid. No backpressure; a beat is accepted on every cycle this is high.
- `B_in` input 32: lane0 = `[15:0]`, lane1 = `[31:16]`.
- `idx_in` input 10: flat beat index from the multiply stage.
- `h_in` input 10: tag travelling with the beat.
- `e_in` input 16: error term; present only with `ROW_ACC_ERROR_EN`.
- `b_valid` output 1: one-cycle pulse, a row result is on `b_out`.
- `b_out` output 16: row inner product mod 2^16.
- `b_row` output 10: row number of `b_out`, 0..ROWS-1.
- `h_out` output 10: `h_in` of the row's final beat.
- `matrix_done` output 1: pulses together with `b_valid` for row ROWS-1.
- `seq_err` output 1: sticky sequencing-error flag.

## Operation
- Internal state:
  - `acc[15:0]`.
  - `beat_cnt` (0..BEATS-1).
  - `row_cnt` (0..ROWS-1).
  - `exp_idx[9:0]` (0..ROWS*BEATS-1).
  - FSM {IDLE, ACCUM}.
- IDLE: no beat of the current row accepted yet.
  - On `B_valid`: `acc <= lane0 + lane1`.
  - If BEATS==1, emit immediately and stay in IDLE; otherwise go to ACCUM.
- ACCUM: on `B_valid`, `acc <= acc + lane0 + lane1`.
  - If `beat_cnt == BEATS-1`: emit and return to IDLE.
- Cycles with `B_valid=0` change no state; gaps of any length are allowed mid-row.
- Arithmetic: all sums are 16-bit, carries discarded (mod 2^16). Lanes are treated as unsigned.
- Emit, on the cycle after the final beat:
  - `b_out` = final sum (plus `e_in` with the macro).
  - `b_row` = `row_cnt`; `h_out` = `h_in` of the final beat.
  - `b_valid = 1` for exactly one cycle.
  - `row_cnt` increments and wraps ROWS-1 → 0.
  - `matrix_done = 1` when the emitted row is ROWS-1.
- Back-to-back rows: a beat on the cycle immediately after a final beat starts the next row. No bubble; the accumulator restarts from the new beat's lanes, not from the old `acc`.
- Index check, on every accepted beat:
  - If `idx_in != exp_idx`, set `seq_err` (held until reset).
  - The beat is still accumulated and counted as normal.
  - `exp_idx` increments on each accepted beat and wraps at ROWS*BEATS-1 → 0.
- `b_out`, `b_row` and `h_out` hold their last values while `b_valid=0`.

## Timing
- Reset (`rst_in` high at a clock edge): all of the following are 0 and FSM = IDLE:
  - Outputs: `b_valid`, `matrix_done`, `seq_err`, `b_out`, `b_row`, `h_out`.
  - Internal state: `acc`, `beat_cnt`, `row_cnt`, `exp_idx`.
- Reset mid-row discards the partial sum; no result is emitted for that row. The next beat must carry `idx_in=0`.
- Latency: final beat accepted at edge N → `b_valid` high during cycle N+1.
- Throughput: one beat per cycle sustained; one row result every BEATS cycles.
- `rst_in` has priority over `B_valid` on the same edge.

## Configuration
- `ROW_ACC_ERROR_EN` defined:
  - `e_in` port exists.
  - `e_in` is sampled on the final-beat cycle of each row.
  - `b_out = (sum + e_in) mod 2^16`.
- Not defined: `e_in` port absent; `b_out = sum`. All other behaviour is identical.

## Test plan
All scenarios use ROW_LEN=4, ROWS=2 (BEATS=2).
- Basic row: beats idx0 `B_in=0x0002_0001`, idx1 `0x0004_0003`, `h_in=0x05` on idx1 → next cycle `b_valid=1`, `b_out=0x000A`, `b_row=0`, `h_out=0x05`, `seq_err=0`.
- Wrap-around and gaps:
  - Stimulus: idx0 `0xFFFF_0001`, three idle cycles, then idx1 `0x0000_0002`.
  - Expected: `b_out=0x0002`, `b_valid` only one cycle after idx1.
- Back-to-back rows and matrix end:
  - Stimulus: idx0..3 on consecutive cycles, all `0x0001_0001`.
  - Expected: `b_out=0x0004` twice (`b_row` 0 then 1), spaced two cycles apart; `matrix_done=1` only with row 1.
  - Then: a following idx0 is accepted without `seq_err`.
- Sequence error: idx0 then `idx_in=3` → `seq_err=1` and stays 1; the row still emits with the sum of both beats.
- Reset mid-row: idx0 `0x0010_0010`, then `rst_in` pulse, then idx0 `0x0001_0001`, idx1 `0x0001_0001` → single emit `b_out=0x0004`, `b_row=0`.
- Macro on: Basic-row stimulus with `e_in=0xFFFF` on the final beat → `b_out=0x0009`.
